// File: rtl/phy_mdio_speed_ctrl.sv
// Clause-22 MDIO master: writes BMCR once after reset/restart, then polls a PHY status
// register and derives the RGMII speed code and link state from each good read.
module phy_mdio_speed_ctrl #(
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter int unsigned MDC_DIV       = 20,
    parameter int unsigned POLL_INTERVAL = 100000,
    parameter logic [15:0] BMCR_INIT     = 16'h9140,
    parameter logic [4:0]  STATUS_REG    = 5'h11,
    parameter int unsigned LINK_BIT      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic       mdc,
    input  logic       mdio_i,
    output logic       mdio_o,
    output logic       mdio_t,
    output logic [1:0] speed,
    output logic       link_up,
    output logic       speed_valid,
    output logic       busy,
    output logic       rd_error
);
    localparam int unsigned DivW  = $clog2(MDC_DIV);
    localparam int unsigned WaitW = $clog2(POLL_INTERVAL + 1);
    localparam logic [DivW-1:0]  DivMax  = DivW'(MDC_DIV - 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(POLL_INTERVAL - 1);
    localparam logic [3:0]       LinkIdx = 4'(LINK_BIT);

    // Frame bits 1..63; bit 0 is always a preamble 1 driven at frame start.
    localparam logic [62:0] WrFrame =
        {31'h7FFF_FFFF, 2'b01, 2'b01, PHY_ADDR, 5'd0, 2'b10, BMCR_INIT};
    localparam logic [62:0] RdFrame =
        {31'h7FFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STATUS_REG, 18'h3_FFFF};

    typedef enum logic [1:0] {StInitWr, StWait, StPollRd} state_e;

    state_e            state_q;
    logic              busy_q, mdc_q, mdio_o_q, mdio_t_q, high_q, pend_q;
    logic [DivW-1:0]   div_q;
    logic [5:0]        bit_q;
    logic [62:0]       tx_q;
    logic [16:0]       rx_q;
    logic [WaitW-1:0]  wait_q;
    logic [1:0]        speed_q;
    logic              link_q, valid_q, err_q;
    logic              start_go, start_wr;
    logic [15:0]       rx_data;

    assign rx_data = rx_q[15:0];

    always_comb begin
        start_go = 1'b0;
        start_wr = 1'b0;
        if (!busy_q) begin
            unique case (state_q)
                StWait: begin
                    start_wr = restart || pend_q;
                    start_go = start_wr || (wait_q == WaitMax);
                end
                StInitWr: begin
                    start_go = 1'b1;
                    start_wr = 1'b1;
                end
                default: start_go = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StInitWr;
            busy_q   <= 1'b0;
            mdc_q    <= 1'b0;
            mdio_o_q <= 1'b1;
            mdio_t_q <= 1'b1;
            high_q   <= 1'b0;
            pend_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            wait_q   <= '0;
            speed_q  <= 2'b10;
            link_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (busy_q) begin
            if (restart) pend_q <= 1'b1;
            // mdio_i is captured on the first cycle of each mdc high phase.
            if (high_q && div_q == '0) rx_q <= {rx_q[15:0], mdio_i};
            if (div_q != DivMax) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q <= '0;
                if (!high_q) begin
                    high_q <= 1'b1;
                    mdc_q  <= 1'b1;
                end else begin
                    high_q <= 1'b0;
                    mdc_q  <= 1'b0;
                    if (bit_q == 6'd63) begin
                        busy_q   <= 1'b0;
                        mdio_o_q <= 1'b1;
                        mdio_t_q <= 1'b1;
                        bit_q    <= '0;
                        wait_q   <= '0;
                        state_q  <= StWait;
                        if (state_q == StPollRd) begin
                            if (rx_q[16]) begin
                                err_q <= 1'b1;
                            end else begin
                                link_q  <= rx_data[LinkIdx];
                                valid_q <= rx_data[LinkIdx] && (rx_data[15:14] != 2'b11);
                                if (rx_data[15:14] == 2'b11) err_q <= 1'b1;
                                else speed_q <= rx_data[15:14];
                            end
                        end
                    end else begin
                        bit_q    <= bit_q + 6'd1;
                        tx_q     <= {tx_q[61:0], 1'b1};
                        mdio_o_q <= tx_q[62];
                        mdio_t_q <= (state_q == StPollRd) && (bit_q >= 6'd45);
                    end
                end
            end
        end else if (start_go) begin
            state_q  <= start_wr ? StInitWr : StPollRd;
            busy_q   <= 1'b1;
            mdio_o_q <= 1'b1;
            mdio_t_q <= 1'b0;
            tx_q     <= start_wr ? WrFrame : RdFrame;
            div_q    <= '0;
            high_q   <= 1'b0;
            bit_q    <= '0;
            if (start_wr) begin
                err_q  <= 1'b0;
                pend_q <= 1'b0;
            end
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign mdc         = mdc_q;
    assign mdio_o      = mdio_o_q;
    assign mdio_t      = mdio_t_q;
    assign speed       = speed_q;
    assign link_up     = link_q;
    assign speed_valid = valid_q;
    assign busy        = busy_q;
    assign rd_error    = err_q;
endmodule

// File: tb/tb_phy_mdio_speed_ctrl.sv
// Bench for phy_mdio_speed_ctrl: frame-timeline model with an MDIO PHY responder,
// per-cycle pin/status comparison, and a few hand-computed literal expectations.
module tb_phy_mdio_speed_ctrl;
    localparam int unsigned D        = 4;
    localparam int unsigned P        = 40;
    localparam int unsigned FrameLen = 128 * D;
    localparam int unsigned LinkBit  = 10;

    logic clk = 1'b0, rst = 1'b1, restart = 1'b0, mdio_i = 1'b1;
    logic mdc, mdio_o, mdio_t, link_up, speed_valid, busy, rd_error;
    logic [1:0] speed;

    phy_mdio_speed_ctrl #(
        .PHY_ADDR(5'd1),
        .MDC_DIV(D),
        .POLL_INTERVAL(P)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .mdc(mdc), .mdio_i(mdio_i),
        .mdio_o(mdio_o), .mdio_t(mdio_t), .speed(speed), .link_up(link_up),
        .speed_valid(speed_valid), .busy(busy), .rd_error(rd_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int unsigned cyc = 0;
    // Model: mode 0 = idle after reset, 1 = frame on wire, 2 = waiting between frames.
    int m_mode = 0;
    bit m_wr = 1'b0, m_pend = 1'b0, m_link = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    bit m_badta = 1'b0;
    int unsigned m_t0 = 0, m_tend = 0;
    logic [1:0] m_speed = 2'b10;
    logic [15:0] m_data = '0;
    int n_reads = 0;
    int lit_idx = -1;
    logic [63:0] wr_bits, rd_bits;

    logic [15:0] ans_data[6] = '{16'h4400, 16'h8400, 16'h0000, 16'h4400, 16'hC400, 16'h4400};
    bit          ans_bad[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // {speed, link_up, speed_valid, rd_error} right after each directed read.
    logic [4:0]  lit_tab[6]  = '{5'b01_1_1_0, 5'b10_1_1_0, 5'b00_0_0_0,
                                 5'b00_0_0_1, 5'b00_1_0_1, 5'b01_1_1_1};

    task automatic expect_lit(input string name, input logic [63:0] got,
                              input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic start_frame(input bit wr);
        m_mode = 1;
        m_wr   = wr;
        m_t0   = cyc;
        if (!wr) begin
            if (n_reads < 6) begin
                m_data  = ans_data[n_reads];
                m_badta = ans_bad[n_reads];
            end else begin
                m_data  = 16'($urandom);
                m_badta = ($urandom_range(0, 5) == 0);
            end
            n_reads++;
        end
    endtask

    task automatic decode();
        if (m_badta) begin
            m_err = 1'b1;
        end else begin
            m_link  = m_data[LinkBit];
            m_valid = m_data[LinkBit] && (m_data[15:14] != 2'b11);
            if (m_data[15:14] == 2'b11) m_err = 1'b1;
            else m_speed = m_data[15:14];
        end
        lit_idx = n_reads - 1;
    endtask

    task automatic advance(input bit r_rst, input bit r_rs);
        if (r_rst) begin
            m_mode = 0; m_pend = 0; m_speed = 2'b10;
            m_link = 0; m_valid = 0; m_err = 0;
        end else begin
            case (m_mode)
                0: start_frame(1'b1);
                1: begin
                    if (r_rs) m_pend = 1'b1;
                    if (cyc - m_t0 == FrameLen) begin
                        if (!m_wr) decode();
                        m_mode = 2;
                        m_tend = cyc;
                    end
                end
                default: begin
                    if (r_rs || m_pend) begin
                        m_pend = 1'b0;
                        m_err  = 1'b0;
                        start_frame(1'b1);
                    end else if (cyc - m_tend == P) begin
                        start_frame(1'b0);
                    end
                end
            endcase
        end
    endtask

    task automatic check();
        int unsigned rel, b, ph;
        logic e_mdc, e_o, e_t;
        logic [8:0] exp_v, act_v;
        e_mdc = 1'b0; e_o = 1'b1; e_t = 1'b1;
        if (m_mode == 1) begin
            rel   = cyc - m_t0;
            b     = rel / (2 * D);
            ph    = rel % (2 * D);
            e_mdc = (ph >= D);
            e_t   = !m_wr && (b >= 46);
            e_o   = e_t ? 1'b1 : (m_wr ? wr_bits[63 - b] : rd_bits[63 - b]);
        end
        exp_v = {e_mdc, e_o, e_t, m_speed, m_link, m_valid, m_mode == 1, m_err};
        act_v = {mdc, mdio_o, mdio_t, speed, link_up, speed_valid, busy, rd_error};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL pins at cyc %0d: got %b, expected %b (mdc,o,t,speed,link,valid,busy,err)",
                     cyc, act_v, exp_v);
        end
    endtask

    task automatic drive_phy();
        int unsigned b;
        mdio_i = 1'b1;
        if (m_mode == 1 && !m_wr) begin
            b = (cyc - m_t0) / (2 * D);
            if (b == 47) mdio_i = m_badta;
            else if (b >= 48) mdio_i = m_data[63 - b];
        end
    endtask

    task automatic step();
        bit r_rst, r_rs;
        r_rst = rst;
        r_rs  = restart;
        @(posedge clk);
        #1;
        cyc++;
        advance(r_rst, r_rs);
        check();
        if (lit_idx >= 0) begin
            if (lit_idx < 6)
                expect_lit("decode_literal", {59'd0, speed, link_up, speed_valid, rd_error},
                           {59'd0, lit_tab[lit_idx]});
            lit_idx = -1;
        end
        drive_phy();
    endtask

    initial begin
        int cnt, guard, tbad, rises;
        logic prev_mdc;
        logic [63:0] cap;
        wr_bits = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h9140};
        rd_bits = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'h11, 18'h3_FFFF};

        rst = 1'b1;
        repeat (3) step();
        expect_lit("reset_state", {mdc, mdio_o, mdio_t, speed, link_up, speed_valid, busy,
                                   rd_error}, 9'b0_1_1_10_0_0_0_0);
        rst = 1'b0;

        // Init write, observed purely on the pins.
        guard = 0;
        while (busy !== 1'b1 && guard < 20) begin step(); guard++; end
        cnt = 0; tbad = 0; rises = 0; cap = '0; prev_mdc = 1'b0; guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            cnt++;
            if (mdio_t !== 1'b0) tbad++;
            if (mdc === 1'b1 && prev_mdc === 1'b0) begin
                cap = {cap[62:0], mdio_o};
                rises++;
            end
            prev_mdc = mdc;
            step();
            guard++;
        end
        expect_lit("init_busy_cycles", cnt, 512);
        expect_lit("init_mdc_rises", rises, 64);
        expect_lit("init_frame_bits", cap, 64'hFFFF_FFFF_5082_9140);
        expect_lit("init_mdio_t_driven", tbad, 0);

        cnt = 0; guard = 0;
        while (busy !== 1'b1 && guard < 1000) begin step(); cnt++; guard++; end
        expect_lit("poll_spacing", cnt, P);

        // Directed reads, then a restart at bit 20 of the sixth read.
        guard = 0;
        while (!(n_reads == 6 && m_mode == 1 && !m_wr && cyc - m_t0 == 160) && guard < 20000)
        begin
            step();
            guard++;
        end
        expect_lit("reach_read_bit20", guard < 20000, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        guard = 0;
        while (busy === 1'b1 && guard < 1000) begin step(); guard++; end
        expect_lit("restart_err_held_at_end", rd_error, 1);
        step();
        expect_lit("restart_write_start", {busy, mdio_t, rd_error}, 3'b100);

        // Reset at bit 30 of the following write frame.
        guard = 0;
        while (!(m_mode == 1 && cyc - m_t0 == 240) && guard < 2000) begin step(); guard++; end
        expect_lit("reach_bit30", guard < 2000, 1);
        rst = 1'b1;
        step();
        expect_lit("rst_midframe", {mdc, mdio_o, mdio_t, speed, link_up, speed_valid, busy,
                                    rd_error}, 9'b0_1_1_10_0_0_0_0);
        rst = 1'b0;

        for (int i = 0; i < 12000; i++) begin
            rst     = ($urandom_range(0, 2999) == 0);
            restart = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        restart = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
